instr_byte_fetch_unit: RTL and testbench
========================================

Name: instr_byte_fetch_unit

Overview:
- Processor-side reader of the byte-wide, big-endian instruction memory that the system bench fills.
- Issues four byte reads per instruction and assembles them into a 32-bit word.
- Hands the word to the decode stage over a valid/ready handshake and accepts branch redirects.
- Counts consecutive accepted NOPs (all-zero words) and enters a halt state after a programmable count. This gives the core a self-terminating end-of-program condition.

Parameters:
- ADDR_W, 8, byte-address width; all PC arithmetic is modulo 2^ADDR_W.
- RESET_PC, 0, byte address of the first fetch after reset; must be a multiple of 4.
- NOP_HALT_COUNT, 4, number of consecutive accepted NOPs that causes halt; legal range 1..7.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_rd_en  out  1  byte read strobe.
- mem_addr  out  ADDR_W  byte address of the read.
- mem_rd_data  in  8  read data; valid the cycle after the strobe.
- instr  out  32  assembled instruction; byte at pc is [31:24], pc+3 is [7:0].
- instr_pc  out  ADDR_W  byte address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  consumer accepts when valid & ready.
- redirect_en  in  1  branch/jump redirect request.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored (forced 0).
- halted  out  1  NOP halt reached.
- nop_count  out  3  consecutive accepted NOPs, saturating at NOP_HALT_COUNT.

Behaviour:
- Reset (while reset=1):
  - pc=RESET_PC, state FETCH, byte index 0.
  - All outputs 0, except mem_addr=RESET_PC.
  - Any pending read is discarded.
- States: FETCH, HOLD, HALT.
- FETCH:
  - Cycles k=0..3: mem_rd_en=1, mem_addr=pc+k (wrapping).
  - Byte k is captured at the end of cycle k+1 into instr bits [31-8k:24-8k].
  - At the end of cycle 4 the state moves to HOLD.
  - instr_valid=1 from cycle 5, which is the first-fetch latency after reset release or redirect.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable until transfer.
  - mem_rd_en=0.
  - On valid & ready: pc=pc+4 (wrapping), update nop_count, then either go to FETCH (instr_valid=0 next cycle) or go to HALT.
  - Throughput is one instruction per 6 cycles when ready is held high.
- NOP counting, on transfer only:
  - instr==32'h0: nop_count=min(nop_count+1, NOP_HALT_COUNT).
  - Otherwise nop_count=0.
  - If the updated count equals NOP_HALT_COUNT: go to HALT.
- HALT:
  - halted=1, mem_rd_en=0, instr_valid=0.
  - Only redirect or reset leaves HALT.
- Redirect (priority below reset, above everything else):
  - Effect: pc=redirect_pc&~3, byte index 0, state FETCH next cycle, instr_valid=0 next cycle.
  - Read data returning from an aborted fetch is dropped.
  - No new read is issued in the redirect cycle itself.
- Redirect cases:
  - Redirect in the same cycle as a transfer: the transfer counts (nop_count updates), but redirect sets pc and the next state is FETCH, even if the NOP count reached halt.
  - Redirect while HALT: halted=0 next cycle and nop_count=0.
- Wrap-around: pc=2^ADDR_W-4 fetches the top four bytes, then the next pc=0.
- instr_ready high with instr_valid low: no effect.
- Reset asserted mid-fetch or mid-HOLD: immediate return to reset state on that edge; no transfer occurs.

Test Plan:
- Reset, then memory bytes 0..3 = 20 0a 00 0a with ready=1 -> mem_addr 0,1,2,3 on cycles 0-3; instr_valid rises cycle 5 with instr=32'h200a000a, instr_pc=0; next fetch starts at address 4.
- Hold ready=0 for 10 cycles in HOLD -> instr and instr_pc stable, mem_rd_en=0, no pc change; ready=1 -> single transfer.
- Program of add 01 8a 58 20 followed by zero words, NOP_HALT_COUNT=4 -> nop_count 1,2,3,4 on successive transfers; halted=1 after the 4th; mem_rd_en stays 0; the sequence 0,0,0,non-zero,0 resets the count to 0 then 1.
- Redirect_en with redirect_pc=8'h27 during byte 2 of a fetch -> fetch restarts at address 8'h24 the next cycle; the stale byte is not merged; instr_pc=8'h24.
- Halted, then redirect to 8'h00 -> halted=0, nop_count=0, fetch resumes at address 0; a redirect in the same cycle as the 4th NOP transfer -> no halt.
- RESET_PC=8'hFC -> reads FC,FD,FE,FF, then the next instruction fetches from address 0; reset asserted mid-fetch -> all outputs 0 and mem_addr=RESET_PC on the next cycle.

Source files
------------

// File: rtl/instr_byte_fetch_unit.sv
// Instruction fetch unit: reads four big-endian bytes per instruction, hands the
// assembled word to decode over valid/ready, and halts after a run of accepted NOPs.
module instr_byte_fetch_unit #(
    parameter int                ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int                NOP_HALT_COUNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [2:0]        nop_count
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_t;

    localparam logic [2:0]        NOP_MAX   = 3'(NOP_HALT_COUNT);
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        idx_q, idx_d;
    logic [31:0]       instr_q, instr_d;
    logic [2:0]        nop_q, nop_d;
    logic [2:0]        nop_upd;
    logic              xfer;

    // idx_q counts read cycles issued; byte idx_q-1 returns while idx_q is 1..4.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        instr_d = instr_q;
        nop_d   = nop_q;
        xfer    = (state_q == S_HOLD) && instr_ready;
        nop_upd = 3'd0;
        if (instr_q == 32'h0) begin
            nop_upd = (nop_q >= NOP_MAX) ? NOP_MAX : nop_q + 3'd1;
        end

        case (state_q)
            S_FETCH: begin
                case (idx_q)
                    3'd1: instr_d[31:24] = mem_rd_data;
                    3'd2: instr_d[23:16] = mem_rd_data;
                    3'd3: instr_d[15:8]  = mem_rd_data;
                    3'd4: begin
                        instr_d[7:0] = mem_rd_data;
                        state_d      = S_HOLD;
                    end
                    default: ;
                endcase
                if (idx_q != 3'd4) begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_HOLD: begin
                if (xfer) begin
                    nop_d   = nop_upd;
                    pc_d    = pc_q + ADDR_W'(4);
                    idx_d   = 3'd0;
                    state_d = (nop_upd == NOP_MAX) ? S_HALT : S_FETCH;
                end
            end
            default: ;
        endcase

        // A redirect wins over halt and drops any byte still returning from the old fetch.
        if (redirect_en) begin
            pc_d    = redirect_pc & WORD_MASK;
            idx_d   = 3'd0;
            state_d = S_FETCH;
            instr_d = instr_q;
            if (state_q == S_HALT) begin
                nop_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            idx_q   <= 3'd0;
            nop_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            nop_q   <= nop_d;
        end
    end

    assign mem_rd_en   = !reset && (state_q == S_FETCH) && (idx_q != 3'd4) && !redirect_en;
    assign mem_addr    = reset ? RESET_PC : pc_q + ADDR_W'(idx_q);
    assign instr_valid = !reset && (state_q == S_HOLD);
    assign instr       = instr_valid ? instr_q : 32'h0;
    assign instr_pc    = instr_valid ? pc_q : '0;
    assign halted      = !reset && (state_q == S_HALT);
    assign nop_count   = reset ? 3'd0 : nop_q;

endmodule

// File: tb/tb_instr_byte_fetch_unit.sv
// Scoreboard bench for instr_byte_fetch_unit: one instance at RESET_PC=0 for the
// main program flow, one at RESET_PC=8'hFC for wrap-around and mid-fetch reset.
module tb_instr_byte_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_rd_en, instr_valid, instr_ready, redirect_en, halted;
    logic [7:0]  mem_addr, mem_rd_data, instr_pc, redirect_pc;
    logic [31:0] instr;
    logic [2:0]  nop_count;

    logic        b_reset, b_mem_rd_en, b_instr_valid, b_instr_ready, b_redirect_en, b_halted;
    logic [7:0]  b_mem_addr, b_mem_rd_data, b_instr_pc, b_redirect_pc;
    logic [31:0] b_instr;
    logic [2:0]  b_nop_count;

    instr_byte_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .NOP_HALT_COUNT(4)) dut_a (
        .clk(clk), .reset(reset), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .halted(halted), .nop_count(nop_count)
    );

    instr_byte_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFC), .NOP_HALT_COUNT(4)) dut_b (
        .clk(clk), .reset(b_reset), .mem_rd_en(b_mem_rd_en), .mem_addr(b_mem_addr),
        .mem_rd_data(b_mem_rd_data), .instr(b_instr), .instr_pc(b_instr_pc),
        .instr_valid(b_instr_valid), .instr_ready(b_instr_ready), .redirect_en(b_redirect_en),
        .redirect_pc(b_redirect_pc), .halted(b_halted), .nop_count(b_nop_count)
    );

    logic [7:0] mem [256];

    always @(posedge clk) if (mem_rd_en)   mem_rd_data   <= mem[mem_addr];
    always @(posedge clk) if (b_mem_rd_en) b_mem_rd_data <= mem[b_mem_addr];

    typedef struct packed {
        logic [31:0] word;
        logic [7:0]  pc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            exp_t e;
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_a_extra: got instr %h pc %h, required no transfer", instr, instr_pc);
            end else begin
                e = qa.pop_front();
                chk("sb_a_instr", instr, e.word);
                chk("sb_a_pc", {24'h0, instr_pc}, {24'h0, e.pc});
            end
        end
    end

    always @(negedge clk) begin
        if (!b_reset && b_instr_valid && b_instr_ready) begin
            exp_t e;
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_b_extra: got instr %h pc %h, required no transfer", b_instr, b_instr_pc);
            end else begin
                e = qb.pop_front();
                chk("sb_b_instr", b_instr, e.word);
                chk("sb_b_pc", {24'h0, b_instr_pc}, {24'h0, e.pc});
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [7:0] a, input logic [31:0] w);
        mem[a]        = w[31:24];
        mem[a + 8'd1] = w[23:16];
        mem[a + 8'd2] = w[15:8];
        mem[a + 8'd3] = w[7:0];
    endtask

    task automatic wait_valid(input string nm, output bit ok);
        int n;
        n = 0;
        while (!instr_valid && n < 30) begin
            next_cycle();
            #2;
            n++;
        end
        ok = instr_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: instr_valid still 0 after %0d cycles, required 1", nm, n);
        end
    endtask

    task automatic wait_xfer_nop(input string nm, input logic [2:0] exp_nop);
        bit ok;
        wait_valid(nm, ok);
        if (ok) begin
            next_cycle();
            #2;
            chk(nm, {29'h0, nop_count}, {29'h0, exp_nop});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        put_word(8'h00, 32'h200a000a);
        put_word(8'h04, 32'h018a5820);
        put_word(8'h24, 32'hcafef00d);
        put_word(8'h4C, 32'h31000000);
        put_word(8'h80, 32'h11223344);
        put_word(8'h84, 32'haabbccdd);
        put_word(8'hFC, 32'hdeadbeef);

        reset = 1'b1; instr_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 8'h00;
        b_reset = 1'b1; b_instr_ready = 1'b1; b_redirect_en = 1'b0; b_redirect_pc = 8'h00;

        // Reset state
        repeat (3) next_cycle();
        #2;
        chk("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
        chk("rst_addr", {24'h0, mem_addr}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_nop", {29'h0, nop_count}, 32'h0);

        // First fetch: reads at 0..3, valid on cycle 5, then held for 10 cycles
        qa.push_back({32'h200a000a, 8'h00});
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) next_cycle();
            #2;
            if (k < 4) begin
                chk("f1_rd_en", {31'h0, mem_rd_en}, 32'h1);
                chk("f1_addr", {24'h0, mem_addr}, k);
            end else if (k == 4) begin
                chk("f1_rd_en_c4", {31'h0, mem_rd_en}, 32'h0);
                chk("f1_valid_c4", {31'h0, instr_valid}, 32'h0);
            end else begin
                chk("f1_valid_c5", {31'h0, instr_valid}, 32'h1);
                chk("f1_instr_c5", instr, 32'h200a000a);
            end
        end
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            #2;
            chk("hold_instr", instr, 32'h200a000a);
            chk("hold_pc", {24'h0, instr_pc}, 32'h0);
            chk("hold_rd_en", {31'h0, mem_rd_en}, 32'h0);
            chk("hold_valid", {31'h0, instr_valid}, 32'h1);
        end
        next_cycle();
        instr_ready = 1'b1;
        next_cycle();
        #2;
        chk("post_xfer_valid", {31'h0, instr_valid}, 32'h0);
        chk("post_xfer_rd_en", {31'h0, mem_rd_en}, 32'h1);
        chk("post_xfer_addr", {24'h0, mem_addr}, 32'h04);

        // Add followed by four NOPs: count 0,1,2,3,4 then halt
        qa.push_back({32'h018a5820, 8'h04});
        qa.push_back({32'h0, 8'h08});
        qa.push_back({32'h0, 8'h0C});
        qa.push_back({32'h0, 8'h10});
        qa.push_back({32'h0, 8'h14});
        wait_xfer_nop("nop_after_add", 3'd0);
        wait_xfer_nop("nop_1", 3'd1);
        wait_xfer_nop("nop_2", 3'd2);
        wait_xfer_nop("nop_3", 3'd3);
        wait_xfer_nop("nop_4", 3'd4);
        chk("halt_set", {31'h0, halted}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #2;
            chk("halt_rd_en", {31'h0, mem_rd_en}, 32'h0);
            chk("halt_valid", {31'h0, instr_valid}, 32'h0);
            chk("halt_stay", {31'h0, halted}, 32'h1);
        end

        // Redirect out of halt to 0
        qa.push_back({32'h200a000a, 8'h00});
        redirect_en = 1'b1; redirect_pc = 8'h00;
        next_cycle();
        redirect_en = 1'b0;
        #2;
        chk("unhalt_halted", {31'h0, halted}, 32'h0);
        chk("unhalt_nop", {29'h0, nop_count}, 32'h0);
        chk("unhalt_rd_en", {31'h0, mem_rd_en}, 32'h1);
        chk("unhalt_addr", {24'h0, mem_addr}, 32'h0);
        wait_xfer_nop("unhalt_xfer_nop", 3'd0);

        // Sequence 0,0,0,nonzero,0,0,0 then the 4th NOP with a same-cycle redirect
        qa.push_back({32'h0, 8'h40});
        qa.push_back({32'h0, 8'h44});
        qa.push_back({32'h0, 8'h48});
        qa.push_back({32'h31000000, 8'h4C});
        qa.push_back({32'h0, 8'h50});
        qa.push_back({32'h0, 8'h54});
        qa.push_back({32'h0, 8'h58});
        qa.push_back({32'h0, 8'h5C});
        qa.push_back({32'h11223344, 8'h80});
        redirect_en = 1'b1; redirect_pc = 8'h40;
        #1;
        chk("redir_cycle_rd_en", {31'h0, mem_rd_en}, 32'h0);
        next_cycle();
        redirect_en = 1'b0;
        #2;
        chk("redir40_addr", {24'h0, mem_addr}, 32'h40);
        wait_xfer_nop("seq_nop_a", 3'd1);
        wait_xfer_nop("seq_nop_b", 3'd2);
        wait_xfer_nop("seq_nop_c", 3'd3);
        wait_xfer_nop("seq_nonzero", 3'd0);
        wait_xfer_nop("seq_nop_d", 3'd1);
        wait_xfer_nop("seq_nop_e", 3'd2);
        wait_xfer_nop("seq_nop_f", 3'd3);
        wait_valid("xfer_redir_valid", ok);
        if (ok) begin
            redirect_en = 1'b1; redirect_pc = 8'h80;
            next_cycle();
            redirect_en = 1'b0;
            #2;
            chk("xfer_redir_nop", {29'h0, nop_count}, 32'h4);
            chk("xfer_redir_halted", {31'h0, halted}, 32'h0);
            chk("xfer_redir_valid0", {31'h0, instr_valid}, 32'h0);
            chk("xfer_redir_addr", {24'h0, mem_addr}, 32'h80);
            wait_xfer_nop("after_redir_nop", 3'd0);
        end

        // Redirect to 0x27 during byte 2 of the fetch at 0x84
        chk("b2_addr0", {24'h0, mem_addr}, 32'h84);
        next_cycle();
        #2;
        chk("b2_addr1", {24'h0, mem_addr}, 32'h85);
        next_cycle();
        qa.push_back({32'hcafef00d, 8'h24});
        redirect_en = 1'b1; redirect_pc = 8'h27;
        #2;
        chk("b2_redir_rd_en", {31'h0, mem_rd_en}, 32'h0);
        next_cycle();
        redirect_en = 1'b0;
        #2;
        chk("b2_restart_rd_en", {31'h0, mem_rd_en}, 32'h1);
        chk("b2_restart_addr", {24'h0, mem_addr}, 32'h24);
        wait_xfer_nop("b2_nop", 3'd0);
        instr_ready = 1'b0;

        // Second instance: RESET_PC=FC wraps to 0, then reset lands mid-fetch
        qb.push_back({32'hdeadbeef, 8'hFC});
        next_cycle();
        b_reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) next_cycle();
            #2;
            if (k < 4) begin
                chk("wrap_rd_en", {31'h0, b_mem_rd_en}, 32'h1);
                chk("wrap_addr", {24'h0, b_mem_addr}, 32'hFC + k);
            end else if (k == 5) begin
                chk("wrap_valid", {31'h0, b_instr_valid}, 32'h1);
            end else if (k >= 6) begin
                chk("wrap_next_addr", {24'h0, b_mem_addr}, k - 6);
            end
        end
        b_reset = 1'b1;
        next_cycle();
        #2;
        chk("midrst_rd_en", {31'h0, b_mem_rd_en}, 32'h0);
        chk("midrst_addr", {24'h0, b_mem_addr}, 32'hFC);
        chk("midrst_valid", {31'h0, b_instr_valid}, 32'h0);
        chk("midrst_instr", b_instr, 32'h0);
        chk("midrst_pc", {24'h0, b_instr_pc}, 32'h0);
        chk("midrst_halted", {31'h0, b_halted}, 32'h0);
        chk("midrst_nop", {29'h0, b_nop_count}, 32'h0);
        next_cycle();
        b_reset = 1'b0;
        #2;
        chk("rerun_rd_en", {31'h0, b_mem_rd_en}, 32'h1);
        chk("rerun_addr", {24'h0, b_mem_addr}, 32'hFC);
        b_instr_ready = 1'b0;

        repeat (2) next_cycle();
        chk("sb_a_drained", qa.size(), 32'h0);
        chk("sb_b_drained", qb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
